// File: rtl/arx_pkg.sv
// Shared definitions for the ARX forward predictor and its LMS companion stage.
package arx_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  // Accumulator width that holds NA+NB full-width products without overflow.
  function automatic int acc_width(input int data_w, input int coef_w,
                                   input int na, input int nb);
    return data_w + coef_w + clog2(na + nb);
  endfunction

endpackage

// File: rtl/arx_round_sat.sv
// Fixed-point round (half toward +inf) and saturate from ACC_W down to DATA_W.
module arx_round_sat #(
  parameter int ACC_W  = 18,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);
  // One guard bit so the rounding bias can never wrap the sum.
  localparam int R_W = ACC_W + 1;
  localparam logic signed [R_W-1:0] MAXV = R_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [R_W-1:0] MINV = ~MAXV;

  logic signed [R_W-1:0] biased;
  logic signed [R_W-1:0] r;

  generate
    if (FRAC_W > 0) begin : g_rnd
      assign biased = R_W'(acc) + (R_W'(1) <<< (FRAC_W-1));
      assign r      = biased >>> FRAC_W;
    end else begin : g_raw
      assign biased = R_W'(acc);
      assign r      = biased;
    end
  endgenerate

  // Clip to the signed DATA_W range and flag any clipping.
  always_comb begin
    y   = r[DATA_W-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      y   = MAXV[DATA_W-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      y   = MINV[DATA_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/arx_forward_mac.sv
// ARX forward predictor: y_hat = sum a[i]*x[n-i] + sum b[j]*y[n-j] using one
// shared multiplier, one product per cycle, with rounding and saturation.
module arx_forward_mac
  import arx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NA     = 2,
  parameter int NB     = 2,
  parameter int FRAC_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        x_in,
  input  logic [DATA_W-1:0]        y_in,
  input  logic [NA*COEF_W-1:0]     a_coef,
  input  logic [NB*COEF_W-1:0]     b_coef,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y_hat,
  output logic                     y_sat
);
  localparam int NT    = NA + NB;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, NA, NB);
  localparam int PW    = DATA_W + COEF_W;
  localparam int CNT_W = (clog2(NT) > 0) ? clog2(NT) : 1;

  logic [1:0] state, nstate;
  logic [NA-1:0][DATA_W-1:0] x_hist;
  logic [NB-1:0][DATA_W-1:0] y_hist;
  logic [NA-1:0][COEF_W-1:0] a_sh;
  logic [NB-1:0][COEF_W-1:0] b_sh;
  logic signed [ACC_W-1:0]   acc, sum;
  logic [CNT_W-1:0]          cnt;
  logic [DATA_W-1:0]         op_d;
  logic [COEF_W-1:0]         op_c;
  logic signed [PW-1:0]      prod;
  logic signed [DATA_W-1:0]  rs_y;
  logic                      rs_sat;
  logic                      accept, last;

  // Flush takes priority over a sample offered in the same cycle.
  assign accept = (state == S_IDLE) && in_valid && !flush;
  assign last   = (cnt == CNT_W'(NT-1));

  // Select the tap for this MAC step: x taps first, then y taps.
  always_comb begin
    op_d = '0;
    op_c = '0;
    for (int i = 0; i < NA; i++)
      if (int'(cnt) == i) begin
        op_d = x_hist[i];
        op_c = a_sh[i];
      end
    for (int j = 0; j < NB; j++)
      if (int'(cnt) == NA + j) begin
        op_d = y_hist[j];
        op_c = b_sh[j];
      end
  end

  assign prod = PW'($signed(op_d)) * PW'($signed(op_c));
  assign sum  = acc + ACC_W'(prod);

  arx_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rs (
    .acc (sum),
    .y   (rs_y),
    .sat (rs_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (accept)    nstate = S_MAC;
      S_MAC:   if (last)      nstate = S_DONE;
      S_DONE:  if (out_ready) nstate = S_IDLE;
      default:                nstate = S_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Histories, coefficient shadows, accumulator and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_hist <= '0;
      y_hist <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      y_hat  <= '0;
      y_sat  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            x_hist <= '0;
            y_hist <= '0;
          end else if (in_valid) begin
            for (int i = NA-1; i > 0; i--) x_hist[i] <= x_hist[i-1];
            for (int j = NB-1; j > 0; j--) y_hist[j] <= y_hist[j-1];
            x_hist[0] <= x_in;
            y_hist[0] <= y_in;
            a_sh      <= a_coef;
            b_sh      <= b_coef;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        S_MAC: begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            y_hat <= rs_y;
            y_sat <= rs_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arx_forward_mac.sv
// Scoreboard bench for arx_forward_mac with default parameters.
module tb_arx_forward_mac;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [7:0]        x_in, y_in;
  logic [15:0]       a_coef, b_coef;
  logic              flush;
  logic              out_valid, out_ready;
  logic signed [7:0] y_hat;
  logic              y_sat;

  arx_forward_mac dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .a_coef(a_coef), .b_coef(b_coef),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .y_hat(y_hat), .y_sat(y_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int y; int sat; string name; } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails  = 0;
  int n_push = 0;
  int n_out  = 0;
  int acc_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pops one expectation per output handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output actual=%0d expected=none", y_hat);
        end else begin
          e = q.pop_front();
          chk({e.name, "_yhat"}, int'(y_hat), e.y);
          chk({e.name, "_ysat"}, int'(y_sat), e.sat);
          n_out++;
        end
      end
    end
  endtask

  // Offer a sample and hold it until accepted; in_valid is left high.
  task automatic send(input string name, input int x, input int y,
                      input int a0, input int a1, input int b0, input int b1,
                      input int ey, input int esat, input bit push);
    exp_t e;
    int k;
    x_in     = 8'(x);
    y_in     = 8'(y);
    a_coef   = {8'(a1), 8'(a0)};
    b_coef   = {8'(b1), 8'(b0)};
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk({name, "_accept_timeout"}, int'(in_ready), 1);
    acc_cyc.push_back(cyc);
    if (push) begin
      e.y = ey; e.sat = esat; e.name = name;
      q.push_back(e);
      n_push++;
    end
    @(posedge clk); #1;
  endtask

  // Count cycles from the accepting edge until out_valid, then finish the handshake.
  task automatic wait_out(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    if (out_valid && out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    fork monitor(); join_none

    reset = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
    a_coef = '0; b_coef = '0; flush = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_yhat",      int'(y_hat), 0);
    chk("rst_ysat",      int'(y_sat), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // identity
    send("ident", 5, 0, 16, 0, 0, 0, 5, 0, 1'b1);
    in_valid = 1'b0;
    wait_out("ident", 4);

    // reset in the middle of a MAC
    send("abort", 50, 0, 16, 0, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0; #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_yhat",      int'(y_hat), 0);
    chk("midrst_in_ready",  int'(in_ready), 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_out_valid", int'(out_valid), 0);
    chk("postrst_in_ready",  int'(in_ready), 1);

    // history shift: 16*1 -> 1, then 16*2 + 32*1 -> 4
    send("hist1", 1, 0, 16, 32, 0, 0, 1, 0, 1'b1);
    in_valid = 1'b0; wait_out("hist1", 4);
    send("hist2", 2, 0, 16, 32, 0, 0, 4, 0, 1'b1);
    in_valid = 1'b0; wait_out("hist2", 4);
    // flush wins over a concurrent sample of 77
    in_valid = 1'b1; x_in = 8'd77;
    do_flush();
    in_valid = 1'b0;
    send("flush3", 3, 0, 16, 32, 0, 0, 3, 0, 1'b1);
    in_valid = 1'b0; wait_out("flush3", 4);

    // feedback taps: 16*10 -> 10, then 16*4 - 16*10 = -96 -> -6
    send("fb1", 0, 10, 0, 0, 16, -16, 10, 0, 1'b1);
    in_valid = 1'b0; wait_out("fb1", 4);
    send("fb2", 0, 4, 0, 0, 16, -16, -6, 0, 1'b1);
    in_valid = 1'b0; wait_out("fb2", 4);

    // saturation and negative rounding
    send("satpos", 127, 127, 127, 0, 127, 0, 127, 1, 1'b1);
    in_valid = 1'b0; wait_out("satpos", 4);
    send("negrnd", 100, 0, -16, 0, 0, 0, -100, 0, 1'b1);
    in_valid = 1'b0; wait_out("negrnd", 4);
    send("satneg", 127, 127, -128, 0, -128, 0, -128, 1, 1'b1);
    in_valid = 1'b0; wait_out("satneg", 4);

    // backpressure with coefficient change during MAC
    out_ready = 1'b0;
    send("bp", 7, 0, 16, 0, 0, 0, 7, 0, 1'b1);
    in_valid = 1'b0;
    a_coef = {8'd50, 8'd99};
    wait_out("bp", 4);
    in_valid = 1'b1; x_in = 8'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid",    int'(out_valid), 1);
      chk("bp_hold_yhat",     int'(y_hat), 7);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready",  int'(in_ready), 1);

    // back-to-back: a=[16,16] after flush gives x[n]+x[n-1]
    do_flush();
    acc_cyc.delete();
    for (int i = 1; i <= 5; i++)
      send($sformatf("b2b%0d", i), i, 0, 16, 16, 0, 0, 2*i-1, 0, 1'b1);
    in_valid = 1'b0;
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;

    chk("queue_drained", q.size(), 0);
    chk("output_count",  n_out, n_push);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
